// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder built from one 4-bit slice, one nibble per clock, LSB nibble first.
// Optional signed-overflow output enabled by defining NIBBLE_ADD_OVERFLOW_FLAG_EN.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q, busy_q, done_q, cout_q;
  logic [3:0]       nib_a, nib_b;
  logic [4:0]       nib5;
  logic [IDXW+1:0]  sh;
  logic             last;
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  // The shared 4-bit slice: select the current nibble and merge its result into sum.
  always_comb begin
    sh    = {idx_q, 2'b00};
    nib_a = 4'(a_q >> sh);
    nib_b = 4'(b_q >> sh);
    nib5  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    sum_d = (sum_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(nib5[3:0]) << sh);
    last  = (idx_q == IDXW'(NIB - 1));
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
    // Same-sign operands producing an opposite-sign MSB equals carry-into-MSB xor carry-out.
    ovf_d = (nib_a[3] == nib_b[3]) && (nib5[3] != nib_a[3]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= nib5[4];
          if (last) begin
            cout_q  <= nib5[4];
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized and directed bench for nibble_serial_add_ctrl at WIDTH=16 and WIDTH=4.
// Handshake: start is taken on a rising edge in IDLE/DONE; done pulses one cycle with sum/cout valid.
module tb_nibble_serial_add_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        start4, cin4, busy4, done4, cout4;
  logic [3:0]  a4, b4, sum4;
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
  logic        ovf16, ovf4;
`endif

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
    , .ovf(ovf16)
`endif
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
    , .ovf(ovf4)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];   // {ovf, cout, sum}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Plain-integer reference: unsigned sum modulo 2^w, carry-out, signed range overflow.
  function automatic logic [17:0] model(input int w, input int a, input int b, input int c);
    int u, half, sa, sb, r;
    logic [17:0] m;
    u    = a + b + c;
    half = 1 << (w - 1);
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    r    = sa + sb + c;
    m[15:0] = 16'(u % (2 * half));
    m[16]   = (u >= 2 * half);
    m[17]   = (r >= half) || (r < -half);
    return m;
  endfunction

  task automatic check_result16(input string tag);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_done"}, done16, 1);
    check({tag, "_sum"}, sum16, e[15:0]);
    check({tag, "_cout"}, cout16, e[16]);
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, ovf16, e[17]);
`endif
  endtask

  // ---------------- drivers ----------------
  // Called at #1 after a rising edge. noise toggles start randomly during RUN.
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input bit noise);
    int cyc, bcnt;
    exp_q.push_back(model(16, int'(a), int'(b), int'(c)));
    a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    check({tag, "_acc_busy"}, busy16, 1);
    check({tag, "_acc_done"}, done16, 0);
    check({tag, "_acc_sum"}, sum16, 0);
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
    check({tag, "_acc_ovf"}, ovf16, 0);
`endif
    bcnt = 1;
    cyc  = 0;
    while (!done16 && cyc < 20) begin
      start16 = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (busy16) bcnt++;
    end
    start16 = 1'b0;
    check({tag, "_latency"}, cyc, 4);
    check({tag, "_busy_cycles"}, bcnt, 4);
    check_result16(tag);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, done16, 0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int cyc;
    logic [17:0] e;
    e = model(4, int'(a), int'(b), int'(c));
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w4_latency", cyc, 1);
    check("w4_sum", sum4, e[3:0]);
    check("w4_cout", cout4, e[16]);
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
    check("w4_ovf", ovf4, e[17]);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int seen_done;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    check("rst_sum", sum16, 0);
    check("rst_cout", cout16, 0);
    check("rst_w4_sum", sum4, 0);
`ifdef NIBBLE_ADD_OVERFLOW_FLAG_EN
    check("rst_ovf", ovf16, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run16("t1234", 16'h1234, 16'h4321, 1'b1, 1'b0);
    run16("tffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run16("t7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run16("t8000", 16'h8000, 16'h8000, 1'b0, 1'b0);

    // Reset during the second RUN cycle; previous cout=1 makes the clear observable.
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy16, 0);
    check("abort_done", done16, 0);
    check("abort_sum", sum16, 0);
    check("abort_cout", cout16, 0);
    seen_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done16) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    run16("tabort_new", 16'hAAAA, 16'h5555, 1'b1, 1'b0);

    // Start held high: second request is taken in the DONE cycle.
    exp_q.push_back(model(16, 16'h0F0F, 16'h00F1, 0));
    exp_q.push_back(model(16, 16'h0001, 16'h0001, 0));
    a16 = 16'h0F0F; b16 = 16'h00F1; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h0001; b16 = 16'h0001;
    cyc = 0;
    while (!done16 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_lat1", cyc, 4);
    check_result16("b2b_first");
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done16 && cyc < 20);
    check("b2b_gap", cyc, 5);
    check_result16("b2b_second");
    start16 = 1'b0;
    @(posedge clk); #1;
    check("b2b_done_drop", done16, 0);

    for (int i = 0; i < 40; i++)
      run16("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          run4(4'(x), 4'(y), 1'(c));

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
